// File: rtl/lsu_mem_requester_pkg.sv
// rtl/lsu_mem_requester_pkg.sv - shared Funct3 codes, FSM states and helpers for the LSU requester
package lsu_pkg;

  // Access size/sign codes carried in instr[14:12]
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_t;

  typedef logic [3:0] be_t;

  // Loads accept all five size codes; stores only the three unsigned-agnostic ones.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return is_load;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_requester_if.sv
// rtl/lsu_mem_requester_if.sv - pipeline request/response and data-memory bundle
interface lsu_mem_requester_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  // Pipeline request side
  logic                  req_valid;
  logic                  req_ready;
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            Funct3;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  // Pipeline response side
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  // Synchronous byte-enabled data memory
  logic [DM_ADDRESS-3:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  // Requester view: the LSU answers the pipeline and drives the memory
  modport slave (
    input  req_valid, MemRead, MemWrite, Funct3, addr, wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_be, mem_wdata
  );

  // Environment view: pipeline plus memory model
  modport master (
    output req_valid, MemRead, MemWrite, Funct3, addr, wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_requester_load_align.sv
// rtl/lsu_mem_requester_load_align.sv - byte-lane select and sign/zero extension of a load word
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_byte_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_byte_off, 3'b000};

  // Pick the addressed byte/half and extend it according to the access code
  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_data = i_rdata;
      F3_BU:   o_data = {24'h000000, w_shifted[7:0]};
      F3_HU:   o_data = {16'h0000, w_shifted[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_requester.sv
// rtl/lsu_mem_requester.sv - MEM-stage load/store requester for a synchronous byte-enabled memory
module lsu_mem_requester #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input logic                clk,
  input logic                reset,
  lsu_mem_requester_if.slave bus
);
  import lsu_pkg::*;

  localparam int WA_W = DM_ADDRESS - 2;

  lsu_state_t        r_state;
  lsu_state_t        w_next;

  // Request fields kept for the later ISSUE/WAIT stages
  logic              r_is_load;
  logic [2:0]        r_funct3;
  logic [1:0]        r_byte_off;

  // Registered outputs
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [WA_W-1:0]   r_mem_addr;
  be_t               r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_accept;
  logic              w_f3_ok;
  logic              w_align_ok;
  logic              w_req_err;
  be_t               w_store_be;
  logic [DATA_W-1:0] w_store_wdata;
  logic [DATA_W-1:0] w_load_data;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  // Classify the incoming request: one direction only, legal size code, natural alignment
  always_comb begin
    w_f3_ok    = f3_legal(bus.MemRead, bus.Funct3);
    w_align_ok = 1'b1;
    case (bus.Funct3[1:0])
      2'b01:   w_align_ok = ~bus.addr[0];
      2'b10:   w_align_ok = (bus.addr[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
    w_req_err = (bus.MemRead == bus.MemWrite) || !w_f3_ok || !w_align_ok;
  end

  // Byte enables and lane-replicated write data for a store
  always_comb begin
    w_store_be    = '0;
    w_store_wdata = '0;
    case (bus.Funct3)
      F3_B: begin
        w_store_be    = be_t'(4'b0001 << bus.addr[1:0]);
        w_store_wdata = {4{bus.wdata[7:0]}};
      end
      F3_H: begin
        w_store_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_store_wdata = {2{bus.wdata[15:0]}};
      end
      F3_W: begin
        w_store_be    = 4'b1111;
        w_store_wdata = bus.wdata;
      end
      default: begin
        w_store_be    = '0;
        w_store_wdata = '0;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .i_rdata    (bus.mem_rdata),
    .i_byte_off (r_byte_off),
    .i_funct3   (r_funct3),
    .o_data     (w_load_data)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: errors skip the memory, stores skip WAIT, loads wait one cycle for read data
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_req_err ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_next = r_is_load ? S_WAIT : S_RESP;
      S_WAIT:  w_next = S_RESP;
      S_RESP: begin
        if (bus.resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latches, memory drive and held response; mem_be lives only for the ISSUE cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_load    <= 1'b0;
      r_funct3     <= '0;
      r_byte_off   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_load  <= bus.MemRead;
            r_funct3   <= bus.Funct3;
            r_byte_off <= bus.addr[1:0];
            if (w_req_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_mem_addr <= bus.addr[DM_ADDRESS-1:2];
              if (bus.MemWrite) begin
                r_mem_be    <= w_store_be;
                r_mem_wdata <= w_store_wdata;
              end else begin
                r_mem_be    <= '0;
                r_mem_wdata <= '0;
              end
            end
          end
        end
        S_ISSUE: begin
          r_mem_be    <= '0;
          r_mem_wdata <= '0;
          if (!r_is_load) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
          end
        end
        S_WAIT: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= w_load_data;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
          end
        end
        default: begin
          r_mem_be <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_be     = r_mem_be;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_requester.sv
// tb/tb_lsu_mem_requester.sv - directed bench for lsu_mem_requester with a synchronous memory model
module tb_lsu_mem_requester;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  lsu_mem_requester_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  lsu_mem_requester #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous byte-enabled memory: read data one cycle after address
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_be[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [3:0]  s_be;
  logic [6:0]  s_maddr;
  logic [31:0] s_wd;
  int          s_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request, then sample ISSUE-cycle memory drive and count cycles to resp_valid
  task automatic send(input logic mr, input logic mw, input logic [2:0] f3,
                      input logic [8:0] a, input logic [31:0] wd);
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.MemRead   = mr;
    bus.MemWrite  = mw;
    bus.Funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    s_be    = bus.mem_be;
    s_maddr = bus.mem_addr;
    s_wd    = bus.mem_wdata;
    s_lat   = 1;
    while (!bus.resp_valid && s_lat < 8) begin
      @(negedge clk);
      s_lat++;
    end
  endtask

  // Accept the response on its first cycle and confirm return to IDLE
  task automatic consume();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("resp_valid_cleared", 32'(bus.resp_valid), 32'd0);
    check("req_ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    send(1'b0, 1'b1, f3, a, wd);
    check({tag, "_be"}, 32'(s_be), 32'(exp_be));
    check({tag, "_maddr"}, 32'(s_maddr), 32'(a[8:2]));
    check({tag, "_wdata"}, s_wd, exp_wd);
    check({tag, "_lat"}, s_lat, 32'd2);
    check({tag, "_err"}, 32'(bus.resp_err), 32'd0);
    check({tag, "_rdata"}, bus.resp_rdata, 32'd0);
    consume();
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] exp_data);
    send(1'b1, 1'b0, f3, a, 32'h0);
    check({tag, "_be"}, 32'(s_be), 32'd0);
    check({tag, "_lat"}, s_lat, 32'd3);
    check({tag, "_err"}, 32'(bus.resp_err), 32'd0);
    check({tag, "_rdata"}, bus.resp_rdata, exp_data);
    consume();
  endtask

  task automatic do_error(input string tag, input logic mr, input logic mw,
                          input logic [2:0] f3, input logic [8:0] a);
    send(mr, mw, f3, a, 32'hFFFF_FFFF);
    check({tag, "_be"}, 32'(s_be), 32'd0);
    check({tag, "_lat"}, s_lat, 32'd1);
    check({tag, "_err"}, 32'(bus.resp_err), 32'd1);
    check({tag, "_rdata"}, bus.resp_rdata, 32'd0);
    consume();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[8] = 32'h0BAD_F00D;
    bus.req_valid  = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.Funct3     = 3'b000;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_be", 32'(bus.mem_be), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;

    // Word 4 evolves: DEADBEEF -> A5ADBEEF -> 8001BEEF -> 80015AEF
    do_store("sw_010", 3'b010, 9'h010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_store("sb_013", 3'b000, 9'h013, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    do_load("lb_013", 3'b000, 9'h013, 32'hFFFF_FFA5);
    do_load("lbu_013", 3'b100, 9'h013, 32'h0000_00A5);
    do_store("sh_012", 3'b001, 9'h012, 32'h0000_8001, 4'b1100, 32'h8001_8001);
    do_load("lh_012", 3'b001, 9'h012, 32'hFFFF_8001);
    do_load("lhu_012", 3'b101, 9'h012, 32'h0000_8001);
    do_store("sb_011", 3'b000, 9'h011, 32'h1234_565A, 4'b0010, 32'h5A5A_5A5A);
    do_load("lb_011", 3'b000, 9'h011, 32'h0000_005A);
    do_load("lw_010", 3'b010, 9'h010, 32'h8001_5AEF);

    do_error("lw_006_misalign", 1'b1, 1'b0, 3'b010, 9'h006);
    do_error("sh_001_misalign", 1'b0, 1'b1, 3'b001, 9'h001);
    do_error("load_f3_011", 1'b1, 1'b0, 3'b011, 9'h010);
    do_error("store_f3_100", 1'b0, 1'b1, 3'b100, 9'h010);
    do_error("rd_and_wr", 1'b1, 1'b1, 3'b010, 9'h010);
    do_error("neither", 1'b0, 1'b0, 3'b010, 9'h010);

    // Backpressure: response must hold while a stray request is ignored
    send(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    check("bp_lat", s_lat, 32'd3);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.MemRead   = 1'b1;
      bus.Funct3    = 3'b010;
      bus.addr      = 9'h000;
      check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp_resp_rdata", bus.resp_rdata, 32'h8001_5AEF);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.MemRead   = 1'b0;
    consume();

    // Reset during ISSUE of SW 0x020 drops the write
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.MemWrite  = 1'b1;
    bus.Funct3    = 3'b010;
    bus.addr      = 9'h020;
    bus.wdata     = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.MemWrite  = 1'b0;
    check("rst_issue_be_pre", 32'(bus.mem_be), 32'hF);
    #1 reset = 1'b1;
    #1;
    check("rst_issue_be_post", 32'(bus.mem_be), 32'd0);
    check("rst_issue_idle", 32'(bus.req_ready), 32'd1);
    check("rst_issue_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_load("lw_020_old", 3'b010, 9'h020, 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
